// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: loader states and word-packing constants.
package program_loader_pkg;

    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream link from the host: the host is the master, the loader is the slave.
interface program_loader_if;

    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/program_loader_byte_packer.sv
// Collects four accepted bytes little-endian into one 32-bit instruction word.
module byte_packer
    import program_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        word_ready
);

    logic [1:0]  byte_idx;
    logic [31:0] word_q;

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            byte_idx <= '0;
            word_q   <= '0;
        end else if (accept) begin
            // Shifting right lands byte 0 in [7:0] once all four have arrived.
            word_q   <= {data, word_q[31:8]};
            byte_idx <= byte_idx + 2'd1;
        end
    end

    assign word       = word_q;
    assign word_ready = accept && (byte_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Program-memory writer: packs a host byte stream into words, writes them from address 0,
// holds the CPU while loading and keeps an XOR checksum of the written words.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int MEM_SIZE   = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic                  abort,
    program_loader_if.slave       byte_in,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error,
    output logic [31:0]           checksum
);

    localparam logic [ADDR_WIDTH:0] MAX_COUNT = (ADDR_WIDTH + 1)'(MEM_SIZE);

    state_t              state_q, state_d;
    logic [ADDR_WIDTH:0] word_idx_q, count_q, idx_next;
    logic [31:0]         checksum_q, packed_word;
    logic                hold_q, accept, word_ready, count_ok, load_go, abort_go;

    assign count_ok = (word_count != '0) && (word_count <= MAX_COUNT);
    assign idx_next = word_idx_q + 1'b1;
    assign accept   = byte_in.in_valid && byte_in.in_ready;

    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (load_go || abort_go),
        .accept     (accept),
        .data       (byte_in.in_data),
        .word       (packed_word),
        .word_ready (word_ready)
    );

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        load_go  = 1'b0;
        abort_go = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (load_start) begin
                    state_d = count_ok ? ST_RECV : ST_ERROR;
                    load_go = count_ok;
                end
            end
            ST_ERROR: begin
                // abort wins over a simultaneous load_start.
                if (abort) begin
                    state_d  = ST_IDLE;
                    abort_go = 1'b1;
                end else if (load_start) begin
                    state_d = count_ok ? ST_RECV : ST_ERROR;
                    load_go = count_ok;
                end
            end
            ST_RECV: begin
                if (abort) begin
                    state_d  = ST_IDLE;
                    abort_go = 1'b1;
                end else if (word_ready) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (abort) begin
                    state_d  = ST_IDLE;
                    abort_go = 1'b1;
                end else begin
                    state_d = (idx_next == count_q) ? ST_DONE : ST_RECV;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            word_idx_q <= '0;
            count_q    <= '0;
            checksum_q <= '0;
            hold_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= (state_d == ST_RECV) || (state_d == ST_WRITE) || (state_d == ST_ERROR);
            if (load_go) begin
                word_idx_q <= '0;
                count_q    <= word_count;
                checksum_q <= '0;
            end else if (abort_go) begin
                checksum_q <= '0;
            end else if (state_q == ST_WRITE) begin
                word_idx_q <= idx_next;
                checksum_q <= checksum_q ^ packed_word;
            end
        end
    end

    assign byte_in.in_ready = (state_q == ST_RECV);
    assign mem_we           = (state_q == ST_WRITE);
    assign mem_addr         = word_idx_q[ADDR_WIDTH-1:0];
    assign mem_wdata        = packed_word;
    assign cpu_hold         = hold_q;
    assign done             = (state_q == ST_DONE);
    assign error            = (state_q == ST_ERROR);
    assign checksum         = checksum_q;

endmodule
